mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/arb_starve_sel.sv | 26 ++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
//   state_t   : sequencer states (IDLE, WAIT_IF, WAIT_DM)
//   owner_t   : which requester currently owns the memory port
//   ADDR_W_DEF: default byte address width
//   STARVE_W  : width of the fetch starvation counter
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 64;
    localparam int unsigned STARVE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IF,
        WAIT_DM
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch, data and memory-side handshakes.
//   slave  : arbiter view (takes if_/dm_ requests, drives mem_ requests)
//   master : environment view (pipeline stages plus memory macro)
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    // Fetch stage
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    // Data-memory stage
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [63:0]       dm_wdata;
    logic [7:0]        dm_wstrb;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [63:0]       dm_rdata;

    // Memory macro
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [7:0]        mem_wstrb;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [63:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/arb_starve_sel.sv
// arb_starve_sel: picks the memory-port owner for the current IDLE cycle.
//   if_req, dm_req : pending requests
//   starve_cnt     : consecutive data grants taken while fetch waited
//   owner          : OWN_DM by default; OWN_IF when fetch is alone or starved
module arb_starve_sel
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                if_req,
    input  logic                dm_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output owner_t              owner
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    always_comb begin
        if (if_req && (!dm_req || (starve_cnt >= STARVE_LIM))) begin
            owner = OWN_IF;
        end else begin
            owner = OWN_DM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction
// fetch and data access, one outstanding transaction at a time.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave modport carrying fetch, data and memory handshakes
// Grants and responses are combinational from mem_gnt / mem_rvalid; the
// registered state only remembers who owns the in-flight transaction.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mem_port_arbiter_if.slave         bus
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    state_t              state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                abit_q, abit_d;
    owner_t              owner;

    arb_starve_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .if_req     (bus.if_req),
        .dm_req     (bus.dm_req),
        .starve_cnt (starve_q),
        .owner      (owner)
    );

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        abit_d        = abit_q;

        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.dm_gnt    = 1'b0;
        bus.dm_rvalid = 1'b0;
        bus.dm_rdata  = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    bus.mem_req = 1'b1;
                    if (owner == OWN_IF) begin
                        // Fetch reads the whole doubleword; the word is picked on return.
                        bus.mem_addr = {bus.if_addr[ADDR_W-1:3], 3'b000};
                        if (bus.mem_gnt) begin
                            bus.if_gnt = 1'b1;
                            starve_d   = '0;
                            abit_d     = bus.if_addr[2];
                            state_d    = WAIT_IF;
                        end
                    end else begin
                        bus.mem_we    = bus.dm_we;
                        bus.mem_addr  = bus.dm_addr;
                        bus.mem_wdata = bus.dm_wdata;
                        bus.mem_wstrb = bus.dm_wstrb;
                        if (bus.mem_gnt) begin
                            bus.dm_gnt = 1'b1;
                            state_d    = WAIT_DM;
                            if (!bus.if_req) begin
                                starve_d = '0;
                            end else if (starve_q < STARVE_LIM) begin
                                starve_d = starve_q + 1'b1;
                            end
                        end
                    end
                end
            end
            WAIT_IF: begin
                if (bus.mem_rvalid) begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = abit_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                    state_d       = IDLE;
                end
            end
            WAIT_DM: begin
                if (bus.mem_rvalid) begin
                    bus.dm_rvalid = 1'b1;
                    bus.dm_rdata  = bus.mem_rdata;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are combinational from the inputs, so silence them while in reset.
        if (!rst_n) begin
            bus.if_gnt    = 1'b0;
            bus.if_rvalid = 1'b0;
            bus.if_rdata  = '0;
            bus.dm_gnt    = 1'b0;
            bus.dm_rvalid = 1'b0;
            bus.dm_rdata  = '0;
            bus.mem_req   = 1'b0;
            bus.mem_we    = 1'b0;
            bus.mem_addr  = '0;
            bus.mem_wdata = '0;
            bus.mem_wstrb = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
            abit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            abit_q   <= abit_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, table-driven check of mem_port_arbiter.
// A vector table walks fetch/data/store/backpressure/stray-response cases;
// hand sequences cover starvation and mid-transaction reset.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        if_req;
        logic [63:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [63:0] dm_addr;
        logic [63:0] dm_wdata;
        logic [7:0]  dm_wstrb;
        logic        mem_gnt;
        logic        mem_rvalid;
        logic [63:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        if_gnt;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        dm_gnt;
        logic        dm_rvalid;
        logic [63:0] dm_rdata;
        logic        mem_req;
        logic        mem_we;
        logic [63:0] mem_addr;
        logic [63:0] mem_wdata;
        logic [7:0]  mem_wstrb;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  e;
    } vec_t;

    localparam logic [63:0] AB = 64'hAAAA_BBBB_CCCC_DDDD;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.ADDR_W(64)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (64),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mi(logic ir, logic [63:0] ia, logic dr, logic dw,
                               logic [63:0] da, logic [63:0] dd, logic [7:0] ds,
                               logic g, logic rv, logic [63:0] rd);
        return '{ir, ia, dr, dw, da, dd, ds, g, rv, rd};
    endfunction

    function automatic out_t mo(logic ig, logic iv, logic [31:0] ird, logic dg,
                                logic dv, logic [63:0] drd, logic mr, logic mw,
                                logic [63:0] ma, logic [63:0] mwd, logic [7:0] ms);
        return '{ig, iv, ird, dg, dv, drd, mr, mw, ma, mwd, ms};
    endfunction

    task automatic drive(input in_t i);
        bus.if_req     = i.if_req;
        bus.if_addr    = i.if_addr;
        bus.dm_req     = i.dm_req;
        bus.dm_we      = i.dm_we;
        bus.dm_addr    = i.dm_addr;
        bus.dm_wdata   = i.dm_wdata;
        bus.dm_wstrb   = i.dm_wstrb;
        bus.mem_gnt    = i.mem_gnt;
        bus.mem_rvalid = i.mem_rvalid;
        bus.mem_rdata  = i.mem_rdata;
    endtask

    function automatic out_t sample();
        return '{bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.dm_gnt, bus.dm_rvalid,
                 bus.dm_rdata, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                 bus.mem_wstrb};
    endfunction

    task automatic chk(input string name, input out_t exp);
        out_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    vec_t vecs[19];

    initial begin
        logic [1:0] own_seq[6];

        checks   = 0;
        failures = 0;

        vecs[0]  = '{"idle",          mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                                      mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{"fetch_gnt",     mi(1, 64'h1004, 0, 0, 0, 0, 0, 1, 0, 0),
                                      mo(1, 0, 0, 0, 0, 0, 1, 0, 64'h1000, 0, 0)};
        vecs[2]  = '{"wait_if",       mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                                      mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{"fetch_resp_hi", mi(0, 0, 0, 0, 0, 0, 0, 0, 1, AB),
                                      mo(0, 1, 32'hAAAABBBB, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{"stray_rvalid",  mi(0, 0, 0, 0, 0, 0, 0, 0, 1, AB),
                                      mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{"both_dm_wins",  mi(1, 64'h2000, 1, 0, 64'h3008, 0, 0, 1, 0, 0),
                                      mo(0, 0, 0, 1, 0, 0, 1, 0, 64'h3008, 0, 0)};
        vecs[6]  = '{"dm_resp",       mi(1, 64'h2000, 0, 0, 0, 0, 0, 0, 1, 64'h0123456789ABCDEF),
                                      mo(0, 0, 0, 0, 1, 64'h0123456789ABCDEF, 0, 0, 0, 0, 0)};
        vecs[7]  = '{"fetch_after",   mi(1, 64'h2000, 0, 0, 0, 0, 0, 1, 0, 0),
                                      mo(1, 0, 0, 0, 0, 0, 1, 0, 64'h2000, 0, 0)};
        vecs[8]  = '{"fetch_resp_lo", mi(0, 0, 0, 0, 0, 0, 0, 0, 1, AB),
                                      mo(0, 1, 32'hCCCCDDDD, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{"store_gnt",     mi(0, 0, 1, 1, 64'h4010, 64'h1122334455667788, 8'h0F, 1, 0, 0),
                                      mo(0, 0, 0, 1, 0, 0, 1, 1, 64'h4010, 64'h1122334455667788, 8'h0F)};
        vecs[10] = '{"store_ack",     mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hFEED),
                                      mo(0, 0, 0, 0, 1, 64'hFEED, 0, 0, 0, 0, 0)};
        vecs[11] = '{"bp_wait1",      mi(0, 0, 1, 0, 64'h5000, 0, 0, 0, 0, 0),
                                      mo(0, 0, 0, 0, 0, 0, 1, 0, 64'h5000, 0, 0)};
        vecs[12] = '{"bp_wait2",      mi(0, 0, 1, 0, 64'h5000, 0, 0, 0, 0, 0),
                                      mo(0, 0, 0, 0, 0, 0, 1, 0, 64'h5000, 0, 0)};
        vecs[13] = '{"bp_wait3",      mi(0, 0, 1, 0, 64'h5000, 0, 0, 0, 0, 0),
                                      mo(0, 0, 0, 0, 0, 0, 1, 0, 64'h5000, 0, 0)};
        vecs[14] = '{"bp_gnt",        mi(0, 0, 1, 0, 64'h5000, 0, 0, 1, 0, 0),
                                      mo(0, 0, 0, 1, 0, 0, 1, 0, 64'h5000, 0, 0)};
        vecs[15] = '{"bp_resp",       mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h77),
                                      mo(0, 0, 0, 0, 1, 64'h77, 0, 0, 0, 0, 0)};
        vecs[16] = '{"if_pending",    mi(1, 64'h6000, 0, 0, 0, 0, 0, 0, 0, 0),
                                      mo(0, 0, 0, 0, 0, 0, 1, 0, 64'h6000, 0, 0)};
        vecs[17] = '{"if_dropped",    mi(0, 0, 1, 0, 64'h7000, 0, 0, 1, 0, 0),
                                      mo(0, 0, 0, 1, 0, 0, 1, 0, 64'h7000, 0, 0)};
        vecs[18] = '{"dropped_resp",  mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h1),
                                      mo(0, 0, 0, 0, 1, 64'h1, 0, 0, 0, 0, 0)};

        // Reset with requests and a response asserted: every output must stay low.
        rst_n = 1'b0;
        drive(mi(1, 64'h1004, 1, 1, 64'h3000, 64'h55, 8'hFF, 1, 1, AB));
        #1;
        chk("reset_quiet", '0);
        @(negedge clk);
        @(negedge clk);
        drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        for (int unsigned k = 0; k < 19; k++) begin
            drive(vecs[k].i);
            #1;
            chk(vecs[k].name, vecs[k].e);
            @(negedge clk);
        end

        // Starvation: both requests held, memory answers one cycle after each grant.
        // Expected owners {if_gnt,dm_gnt}: four data, one fetch, then data again.
        own_seq[0] = 2'b01;
        own_seq[1] = 2'b01;
        own_seq[2] = 2'b01;
        own_seq[3] = 2'b01;
        own_seq[4] = 2'b10;
        own_seq[5] = 2'b01;
        for (int unsigned k = 0; k < 6; k++) begin
            drive(mi(1, 64'h8004, 1, 0, 64'h9000, 0, 0, 1, 0, 0));
            #1;
            chk2($sformatf("starve_gnt%0d", k), {bus.if_gnt, bus.dm_gnt}, own_seq[k]);
            @(negedge clk);
            drive(mi(1, 64'h8004, 1, 0, 64'h9000, 0, 0, 0, 1, 64'h1111_2222_3333_4444));
            #1;
            chk2($sformatf("starve_rv%0d", k), {bus.if_rvalid, bus.dm_rvalid}, own_seq[k]);
            @(negedge clk);
        end

        // Mid-transaction reset: grant a load, reset in WAIT_DM, respond after release.
        drive(mi(0, 0, 1, 0, 64'hA000, 0, 0, 1, 0, 0));
        #1;
        chk("rst_seq_gnt", mo(0, 0, 0, 1, 0, 0, 1, 0, 64'hA000, 0, 0));
        @(negedge clk);
        rst_n = 1'b0;
        drive(mi(1, 64'h1004, 1, 0, 64'hA000, 0, 0, 1, 1, AB));
        #1;
        chk("rst_mid_quiet", '0);
        @(negedge clk);
        drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hBAD));
        #1;
        chk("rst_drop_resp", '0);
        @(negedge clk);
        // After reset a lone fetch still goes straight through.
        drive(mi(1, 64'hC004, 0, 0, 0, 0, 0, 1, 0, 0));
        #1;
        chk("rst_after_fetch", mo(1, 0, 0, 0, 0, 0, 1, 0, 64'hC000, 0, 0));
        @(negedge clk);
        drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, AB));
        #1;
        chk("rst_after_resp", mo(0, 1, 32'hAAAABBBB, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
